// File: rtl/fp_accum_tree.sv
// fp_accum_tree: pipelined multi-operand floating-point sum with per-group accumulation
module fp_accum_tree #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23,
  parameter int NUM_IN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_last,
  input  logic [NUM_IN*(EXPONENT+MANTISSA+1)-1:0] in_data,
  output logic out_valid,
  output logic [EXPONENT+MANTISSA:0] out_data
);
  localparam int W = EXPONENT + MANTISSA + 1;
  localparam int SW = MANTISSA + 3 + $clog2(NUM_IN);
  localparam int EMAX = 2**EXPONENT - 1;
  function automatic logic [MANTISSA:0] align(input logic [EXPONENT-1:0] ex, input logic [MANTISSA-1:0] man,
                                              input logic [EXPONENT-1:0] mx);
    logic [EXPONENT-1:0] d;
    d = mx - ex;
    return (ex == '0 || int'(d) > MANTISSA) ? '0 : {1'b1, man} >> d;
  endfunction
  function automatic logic [W-1:0] normalise(input logic sign, input logic [SW-1:0] mag,
                                             input logic [EXPONENT-1:0] ex);
    int p;
    int e;
    logic [MANTISSA-1:0] m;
    p = 0;
    for (int i = 0; i < SW; i++) if (mag[i]) p = i;
    e = int'(ex) + p - MANTISSA;
    m = MANTISSA'(p >= MANTISSA ? mag >> (p - MANTISSA) : mag << (MANTISSA - p));
    if (mag == '0 || e <= 0) return '0;
    if (e >= EMAX) return {sign, EXPONENT'(EMAX - 1), {MANTISSA{1'b1}}};
    return {sign, EXPONENT'(e), m};
  endfunction
  logic [NUM_IN-1:0][EXPONENT-1:0] op_exp;
  logic [NUM_IN-1:0][MANTISSA:0] op_sig;
  logic [NUM_IN-1:0] op_sign;
  logic [EXPONENT-1:0] max_exp;
  always_comb begin
    max_exp = '0;
    for (int i = 0; i < NUM_IN; i++) max_exp = op_exp[i] > max_exp ? op_exp[i] : max_exp;
  end
  for (genvar k = 0; k < NUM_IN; k++) begin : g_op
    assign op_sign[k] = in_data[k*W+W-1];
    assign op_exp[k] = in_data[k*W+MANTISSA +: EXPONENT];
    assign op_sig[k] = align(op_exp[k], in_data[k*W +: MANTISSA], max_exp);
  end
  logic s1_valid, s1_last;
  logic [EXPONENT-1:0] s1_exp;
  logic [NUM_IN-1:0] s1_sign;
  logic [NUM_IN-1:0][MANTISSA:0] s1_sig;
  logic s2_valid, s2_last, s2_sign;
  logic [EXPONENT-1:0] s2_exp;
  logic [SW-1:0] s2_mag;
  logic s3_valid, s3_last;
  logic [W-1:0] s3_data;
  logic [W-1:0] acc;
  logic signed [SW-1:0] sum;
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_IN; i++) sum = s1_sign[i] ? sum - SW'(s1_sig[i]) : sum + SW'(s1_sig[i]);
  end
  // acc is cleared when a group closes, so it doubles as the zero seed for the next group
  logic [EXPONENT-1:0] a_exp, b_exp, s4_max;
  logic [MANTISSA:0] a_sig, b_sig;
  logic signed [SW-1:0] acc_sum;
  logic [W-1:0] result;
  always_comb begin
    a_exp = s3_data[W-2 -: EXPONENT];
    b_exp = acc[W-2 -: EXPONENT];
    s4_max = a_exp > b_exp ? a_exp : b_exp;
    a_sig = align(a_exp, s3_data[MANTISSA-1:0], s4_max);
    b_sig = align(b_exp, acc[MANTISSA-1:0], s4_max);
    acc_sum = (s3_data[W-1] ? -SW'(a_sig) : SW'(a_sig)) + (acc[W-1] ? -SW'(b_sig) : SW'(b_sig));
    result = normalise(acc_sum[SW-1], acc_sum[SW-1] ? -acc_sum : acc_sum, s4_max);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last <= 1'b0;
      s1_exp <= '0;
      s1_sign <= '0;
      s1_sig <= '0;
      s2_valid <= 1'b0;
      s2_last <= 1'b0;
      s2_sign <= 1'b0;
      s2_exp <= '0;
      s2_mag <= '0;
      s3_valid <= 1'b0;
      s3_last <= 1'b0;
      s3_data <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_last <= in_valid & in_last;
      s1_exp <= max_exp;
      s1_sign <= op_sign;
      s1_sig <= op_sig;
      s2_valid <= s1_valid;
      s2_last <= s1_last;
      s2_sign <= sum[SW-1];
      s2_exp <= s1_exp;
      s2_mag <= sum[SW-1] ? -sum : sum;
      s3_valid <= s2_valid;
      s3_last <= s2_last;
      s3_data <= normalise(s2_sign, s2_mag, s2_exp);
      out_valid <= s3_valid & s3_last;
      if (s3_valid) acc <= s3_last ? '0 : result;
      if (s3_valid & s3_last) out_data <= result;
    end
  end
endmodule

// File: tb/tb_fp_accum_tree.sv
// tb_fp_accum_tree: random and directed beats against an arithmetic reference model
`timescale 1ns/1ps
module tb_fp_accum_tree;
  logic clk, rst_n, in_valid, in_last, out_valid;
  logic [63:0] in_data;
  logic [15:0] out_data;
  fp_accum_tree #(.EXPONENT(5), .MANTISSA(10), .NUM_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data)
  );
  typedef struct {int due; logic [15:0] v;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [15:0] acc_m = 16'h0, last_out = 16'h0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  function automatic logic [15:0] fp_norm(input longint s, input int e);
    longint m;
    if (s == 0) return 16'h0;
    m = s < 0 ? -s : s;
    while (m >= 2048) begin m = m / 2; e++; end
    while (m < 1024) begin m = m * 2; e--; end
    if (e >= 31) return {s < 0, 5'd30, 10'h3FF};
    if (e <= 0) return 16'h0;
    return {s < 0, 5'(e), 10'(m % 1024)};
  endfunction
  function automatic logic [15:0] fp_sum(input logic [63:0] v, input int n);
    int mx, ex;
    longint s, sig;
    mx = 0;
    for (int i = 0; i < n; i++) begin
      ex = int'(v[i*16+10 +: 5]);
      if (ex > mx) mx = ex;
    end
    s = 0;
    for (int i = 0; i < n; i++) begin
      ex = int'(v[i*16+10 +: 5]);
      sig = ex == 0 ? 0 : 1024 + longint'(v[i*16 +: 10]);
      sig = sig / (longint'(1) << (mx - ex));
      s += v[i*16+15] ? -sig : sig;
    end
    return fp_norm(s, mx);
  endfunction
  function automatic logic [15:0] rnd_op();
    int r;
    logic [9:0] m;
    r = $urandom_range(0, 9);
    m = 10'($urandom);
    if (r == 0) return {1'($urandom), 5'd0, m};
    if (r == 1) return {1'($urandom), 5'($urandom_range(27, 30)), m};
    return {1'($urandom), 5'($urandom_range(10, 20)), m};
  endfunction
  task automatic beat(input logic [63:0] d, input logic last, input logic [15:0] k = 16'h0, input bit use_k = 0);
    logic [15:0] bs, r;
    @(negedge clk);
    in_valid = 1'b1;
    in_last = last;
    in_data = d;
    bs = fp_sum(d, 4);
    r = fp_sum({32'h0, acc_m, bs}, 2);
    if (last) begin
      sb.push_back('{due: cyc + 4, v: use_k ? k : r});
      acc_m = 16'h0;
    end else acc_m = r;
  endtask
  task automatic idle(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'($urandom);
      in_data = {$urandom, $urandom};
    end
  endtask
  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    acc_m = 16'h0;
    last_out = 16'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", 32'(out_data), 32'(sb[0].v));
      last_out = sb[0].v;
      void'(sb.pop_front());
    end else begin
      check("idle_valid", 32'(out_valid), 32'd0);
      check("hold_data", 32'(out_data), 32'(last_out));
    end
  end
  initial begin
    logic [63:0] d;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    beat(64'h3C00_3C00_3C00_3C00, 1, 16'h4400, 1);
    beat(64'hC000_4000_BC00_3C00, 1, 16'h0000, 1);
    beat(64'h3C00_3C00_3C00_3C00, 0);
    beat(64'h3C00_3C00_3C00_3C00, 0);
    beat(64'h3C00_3C00_3C00_3C00, 1, 16'h4A00, 1);
    beat(64'h7BFF_7BFF_7BFF_7BFF, 1, 16'h7BFF, 1);
    beat(64'h0000_0000_0000_3800, 1, 16'h3800, 1);
    beat(64'h0000_0000_3C00_0001, 1, 16'h3C00, 1);
    idle(6);
    beat(64'h3C00_3C00_3C00_3C00, 0);
    beat(64'h3C00_3C00_3C00_3C00, 0);
    reset_pulse();
    beat(64'h0000_0000_0000_4000, 1, 16'h4000, 1);
    beat(64'h3C00_3C00_3C00_3C00, 0);
    idle();
    beat(64'h3C00_3C00_3C00_3C00, 1, 16'h4800, 1);
    beat(64'h0000_0000_0000_4000, 1, 16'h4000, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle();
      else begin
        d = {rnd_op(), rnd_op(), rnd_op(), rnd_op()};
        if ($urandom_range(0, 5) == 0) d[31:16] = d[15:0] ^ 16'h8000;
        beat(d, $urandom_range(0, 3) == 0);
      end
    end
    idle(8);
    check("drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
